// File: rtl/mem_arbiter_if.sv
// Memory-side and requester-side signals of the RAM/IO port arbiter.
// The arbiter uses the master view; the RAM, ICache and LSB sit on the slave view.
interface mem_arbiter_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        clear;
  logic        ic_need_mem;
  logic [31:0] ic_addr;
  logic [31:0] ic_ins;
  logic        ic_ins_ready;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic [31:0] lsb_rdata;
  logic        lsb_done;

  modport master (
    input  mem_din, io_buffer_full, clear,
    input  ic_need_mem, ic_addr,
    input  lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
    output mem_dout, mem_a, mem_wr,
    output ic_ins, ic_ins_ready,
    output lsb_rdata, lsb_done
  );

  modport slave (
    output mem_din, io_buffer_full, clear,
    output ic_need_mem, ic_addr,
    output lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  ic_ins, ic_ins_ready,
    input  lsb_rdata, lsb_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO port between ICache fills and LSB loads/stores,
// moving one byte per cycle and assembling little-endian words.
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [2:0]  n, n_nx;
  logic [31:0] base, base_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] data_q, data_nx;
  logic [7:0]  dout_q, dout_nx;
  logic        wr_q, wr_nx;
  logic        src_lsb, src_lsb_nx;
  logic        last_lsb, last_lsb_nx;
  logic [31:0] ic_ins_q, ic_ins_nx;
  logic [31:0] lsb_rdata_q, lsb_rdata_nx;
  logic        ic_rdy_q, ic_rdy_nx;
  logic        lsb_done_q, lsb_done_nx;

  logic        ic_req;
  logic [2:0]  cnt_inc;
  logic [2:0]  done_cnt;
  logic [31:0] wr_addr;

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_HI;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{i, 3'b000} +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      n           <= '0;
      base        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      src_lsb     <= 1'b0;
      last_lsb    <= 1'b0;
      ic_ins_q    <= '0;
      lsb_rdata_q <= '0;
      ic_rdy_q    <= 1'b0;
      lsb_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      n           <= n_nx;
      base        <= base_nx;
      addr_q      <= addr_nx;
      data_q      <= data_nx;
      dout_q      <= dout_nx;
      wr_q        <= wr_nx;
      src_lsb     <= src_lsb_nx;
      last_lsb    <= last_lsb_nx;
      ic_ins_q    <= ic_ins_nx;
      lsb_rdata_q <= lsb_rdata_nx;
      ic_rdy_q    <= ic_rdy_nx;
      lsb_done_q  <= lsb_done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    n_nx         = n;
    base_nx      = base;
    addr_nx      = addr_q;
    data_nx      = data_q;
    dout_nx      = dout_q;
    wr_nx        = wr_q;
    src_lsb_nx   = src_lsb;
    last_lsb_nx  = last_lsb;
    ic_ins_nx    = ic_ins_q;
    lsb_rdata_nx = lsb_rdata_q;
    ic_rdy_nx    = 1'b0;
    lsb_done_nx  = 1'b0;
    ic_req       = bus.ic_need_mem & ~bus.clear;
    cnt_inc      = cnt + 3'd1;
    done_cnt     = cnt + {2'b00, wr_q};
    wr_addr      = base + {29'd0, done_cnt};

    case (state)
      IDLE: begin
        // On a tie the LSB wins unless it also won the previous grant.
        if (bus.lsb_req && (!ic_req || !last_lsb)) begin
          base_nx     = bus.lsb_addr;
          addr_nx     = bus.lsb_addr;
          n_nx        = len_to_n(bus.lsb_len);
          cnt_nx      = '0;
          src_lsb_nx  = 1'b1;
          last_lsb_nx = 1'b1;
          if (bus.lsb_wr) begin
            data_nx  = bus.lsb_wdata;
            dout_nx  = bus.lsb_wdata[7:0];
            wr_nx    = !(is_io(bus.lsb_addr) && bus.io_buffer_full);
            state_nx = WRITE;
          end else begin
            data_nx  = '0;
            state_nx = READ;
          end
        end else if (ic_req) begin
          base_nx     = bus.ic_addr;
          addr_nx     = bus.ic_addr;
          n_nx        = 3'd4;
          cnt_nx      = '0;
          src_lsb_nx  = 1'b0;
          last_lsb_nx = 1'b0;
          data_nx     = '0;
          state_nx    = READ;
        end
      end

      READ: begin
        if (!src_lsb && bus.clear) begin
          state_nx = IDLE;
          addr_nx  = '0;
          cnt_nx   = '0;
        end else begin
          // Address k goes out after edge k; its byte returns two edges later.
          cnt_nx = cnt_inc;
          if (cnt_inc < n)
            addr_nx = base + {29'd0, cnt_inc};
          if (cnt != 3'd0)
            data_nx = put_byte(data_q, cnt[1:0] - 2'd1, bus.mem_din);
          if (cnt == n) begin
            state_nx = DONE;
            if (src_lsb) begin
              lsb_rdata_nx = data_nx;
              lsb_done_nx  = 1'b1;
            end else begin
              ic_ins_nx = data_nx;
              ic_rdy_nx = 1'b1;
            end
          end
        end
      end

      WRITE: begin
        // cnt only moves past a byte once it has actually been strobed out.
        cnt_nx = done_cnt;
        if (done_cnt == n) begin
          wr_nx       = 1'b0;
          lsb_done_nx = 1'b1;
          state_nx    = DONE;
        end else if (is_io(wr_addr) && bus.io_buffer_full) begin
          wr_nx = 1'b0;
        end else begin
          addr_nx = wr_addr;
          dout_nx = get_byte(data_q, done_cnt[1:0]);
          wr_nx   = 1'b1;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.mem_a        = addr_q;
  assign bus.mem_dout     = dout_q;
  assign bus.mem_wr       = wr_q & rdy_in;
  assign bus.ic_ins       = ic_ins_q;
  assign bus.ic_ins_ready = ic_rdy_q & ~bus.clear;
  assign bus.lsb_rdata    = lsb_rdata_q;
  assign bus.lsb_done     = lsb_done_q;

endmodule
